// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_seq_pkg;

    localparam int unsigned MDU_XLEN  = 32;
    localparam int unsigned MDU_CNT_W = 5;

    // RV32M funct3 encodings
    localparam logic [2:0] MDU_OP_MUL    = 3'd0;
    localparam logic [2:0] MDU_OP_MULH   = 3'd1;
    localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
    localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
    localparam logic [2:0] MDU_OP_DIV    = 3'd4;
    localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
    localparam logic [2:0] MDU_OP_REM    = 3'd6;
    localparam logic [2:0] MDU_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // Per-operation control captured at accept
    typedef struct packed {
        logic [2:0] op;
        logic       neg_res;
        logic       neg_rem;
        logic       div_zero;
        logic       div_ovf;
    } mdu_ctl_t;

    function automatic logic mdu_a_signed(input logic [2:0] op);
        return !(op == MDU_OP_MULHU || op == MDU_OP_DIVU || op == MDU_OP_REMU);
    endfunction

    function automatic logic mdu_b_signed(input logic [2:0] op);
        return (op == MDU_OP_MUL || op == MDU_OP_MULH ||
                op == MDU_OP_DIV || op == MDU_OP_REM);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude/sign extraction at accept and result sign correction at finish.
module mdu_sign_fix
    import mdu_seq_pkg::*;
#(
    parameter int unsigned W = MDU_XLEN
) (
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   a_mag_c,
    output logic [W-1:0]   b_mag_c,
    output logic           neg_res_c,
    output logic           neg_rem_c,
    input  logic           fin_neg_res,
    input  logic           fin_neg_rem,
    input  logic [2*W-1:0] prod,
    input  logic [W-1:0]   quot,
    input  logic [W-1:0]   rem,
    output logic [2*W-1:0] prod_fix_c,
    output logic [W-1:0]   quot_fix_c,
    output logic [W-1:0]   rem_fix_c
);

    logic sa;
    logic sb;

    always_comb begin
        sa         = mdu_a_signed(op) & a[W-1];
        sb         = mdu_b_signed(op) & b[W-1];
        a_mag_c    = sa ? (~a + W'(1)) : a;
        b_mag_c    = sb ? (~b + W'(1)) : b;
        neg_res_c  = sa ^ sb;
        // remainder follows the dividend's sign
        neg_rem_c  = sa;
        prod_fix_c = fin_neg_res ? (~prod + (2*W)'(1)) : prod;
        quot_fix_c = fin_neg_res ? (~quot + W'(1)) : quot;
        rem_fix_c  = fin_neg_rem ? (~rem + W'(1)) : rem;
    end

endmodule

// File: rtl/mdu_seq.sv
// Radix-2 iterative RV32M multiply/divide unit with a valid/ready response.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN         = MDU_XLEN,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e            state_q;
    mdu_ctl_t              ctl_q;
    logic [MDU_CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]       opd_q;
    logic [XLEN-1:0]       hi_q;
    logic [XLEN-1:0]       lo_q;

    logic [XLEN-1:0]       a_mag_c;
    logic [XLEN-1:0]       b_mag_c;
    logic                  neg_res_c;
    logic                  neg_rem_c;
    logic [2*XLEN-1:0]     prod_fix_c;
    logic [XLEN-1:0]       quot_fix_c;
    logic [XLEN-1:0]       rem_fix_c;

    logic [XLEN:0]         sum_c;
    logic [XLEN:0]         trial_c;
    logic                  qbit_c;
    logic [XLEN-1:0]       hi_nx_c;
    logic [XLEN-1:0]       lo_nx_c;
    logic [XLEN-1:0]       fin_result_c;
    logic                  div_zero_c;
    logic                  div_ovf_c;
    logic [XLEN-1:0]       spec_result_c;

    mdu_sign_fix #(.W(XLEN)) u_sign_fix (
        .op          (op_i),
        .a           (a_i),
        .b           (b_i),
        .a_mag_c     (a_mag_c),
        .b_mag_c     (b_mag_c),
        .neg_res_c   (neg_res_c),
        .neg_rem_c   (neg_rem_c),
        .fin_neg_res (ctl_q.neg_res),
        .fin_neg_rem (ctl_q.neg_rem),
        .prod        ({hi_nx_c, lo_nx_c}),
        .quot        (lo_nx_c),
        .rem         (hi_nx_c),
        .prod_fix_c  (prod_fix_c),
        .quot_fix_c  (quot_fix_c),
        .rem_fix_c   (rem_fix_c)
    );

    // One iteration: shift-add multiply in {hi,lo}, or restoring divide with hi as remainder
    always_comb begin
        sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        trial_c = {hi_q, lo_q[XLEN-1]};
        qbit_c  = (trial_c >= {1'b0, opd_q});
        if (ctl_q.op[2]) begin
            hi_nx_c = qbit_c ? (trial_c[XLEN-1:0] - opd_q) : trial_c[XLEN-1:0];
            lo_nx_c = {lo_q[XLEN-2:0], qbit_c};
        end else begin
            hi_nx_c = sum_c[XLEN:1];
            lo_nx_c = {sum_c[0], lo_q[XLEN-1:1]};
        end
    end

    // Result selection after the last iteration; divide-by-zero remainder already equals a
    always_comb begin
        if (!ctl_q.op[2]) begin
            fin_result_c = (ctl_q.op[1:0] == 2'b00) ? prod_fix_c[XLEN-1:0]
                                                    : prod_fix_c[2*XLEN-1:XLEN];
        end else if (!ctl_q.op[1]) begin
            fin_result_c = ctl_q.div_zero ? '1 : (ctl_q.div_ovf ? MIN_NEG : quot_fix_c);
        end else begin
            fin_result_c = ctl_q.div_ovf ? '0 : rem_fix_c;
        end
    end

    always_comb begin
        div_zero_c    = op_i[2] && (b_i == '0);
        div_ovf_c     = (op_i == MDU_OP_DIV || op_i == MDU_OP_REM) &&
                        (a_i == MIN_NEG) && (b_i == '1);
        spec_result_c = op_i[1] ? (div_zero_c ? a_i : '0)
                                : (div_zero_c ? '1 : MIN_NEG);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= MDU_IDLE;
            ctl_q        <= '0;
            cnt_q        <= '0;
            opd_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            result_o     <= '0;
            resp_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            req_ready_o  <= 1'b1;
        end else if (flush_i) begin
            state_q      <= MDU_IDLE;
            resp_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            req_ready_o  <= 1'b1;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (req_valid_i) begin
                        ctl_q       <= '{op: op_i, neg_res: neg_res_c, neg_rem: neg_rem_c,
                                         div_zero: div_zero_c, div_ovf: div_ovf_c};
                        cnt_q       <= '0;
                        hi_q        <= '0;
                        lo_q        <= op_i[2] ? a_mag_c : b_mag_c;
                        opd_q       <= op_i[2] ? b_mag_c : a_mag_c;
                        busy_o      <= 1'b1;
                        req_ready_o <= 1'b0;
                        if (FAST_SPECIAL && (div_zero_c || div_ovf_c)) begin
                            state_q      <= MDU_DONE;
                            result_o     <= spec_result_c;
                            resp_valid_o <= 1'b1;
                        end else begin
                            state_q <= MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    hi_q  <= hi_nx_c;
                    lo_q  <= lo_nx_c;
                    cnt_q <= cnt_q + MDU_CNT_W'(1);
                    if (cnt_q == MDU_CNT_W'(XLEN - 1)) begin
                        state_q      <= MDU_DONE;
                        result_o     <= fin_result_c;
                        resp_valid_o <= 1'b1;
                    end
                end
                MDU_DONE: begin
                    if (resp_ready_i) begin
                        state_q      <= MDU_IDLE;
                        resp_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                        req_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= MDU_IDLE;
                    resp_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                    req_ready_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized self-checking bench for mdu_seq against a 64-bit arithmetic reference.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic        clk_i        = 1'b0;
    logic        rst_i        = 1'b1;
    logic        flush_i      = 1'b0;
    logic        req_valid_i  = 1'b0;
    logic        resp_ready_i = 1'b0;
    logic [2:0]  op_i         = '0;
    logic [31:0] a_i          = '0;
    logic [31:0] b_i          = '0;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic        busy_o;
    logic [31:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_i         (op_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .result_o     (result_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request from a negedge, wait for the response, hold it, then hand it off
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        logic [31:0] exp;
        int          lat;
        int          k;
        exp = ref_mdu(op, a, b);
        lat = ref_lat(op, a, b);
        check({tag, "_rdy"}, {63'b0, req_ready_o}, 64'd1);
        op_i = op; a_i = a; b_i = b; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        a_i = $urandom; b_i = $urandom; op_i = 3'($urandom);
        k = 1;
        while (!resp_valid_o && k < 60) begin
            @(negedge clk_i);
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_res"}, {32'b0, result_o}, {32'b0, exp});
        for (int i = 0; i < hold; i++) begin
            req_valid_i = 1'b1;
            op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
            @(negedge clk_i);
            check({tag, "_hold"}, {29'b0, resp_valid_o, req_ready_o, busy_o, result_o},
                  {29'b0, 1'b1, 1'b0, 1'b1, exp});
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        check({tag, "_idle"}, {61'b0, resp_valid_o, req_ready_o, busy_o}, 64'b010);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset", {29'b0, result_o, resp_valid_o, busy_o, req_ready_o}, {29'b0, 32'h0, 3'b001});
        rst_i = 1'b0;
        @(negedge clk_i);

        do_op(MDU_OP_MUL,    32'hFFFF_FFFF, 32'd7,          0, "mul_m1x7");
        do_op(MDU_OP_MULH,   32'hFFFF_FFFF, 32'd7,          0, "mulh_m1x7");
        do_op(MDU_OP_MULHU,  32'hFFFF_FFFF, 32'd7,          0, "mulhu_m1x7");
        do_op(MDU_OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF,  0, "mulhsu_min");
        do_op(MDU_OP_MULH,   32'h8000_0000, 32'h8000_0000,  0, "mulh_minsq");
        do_op(MDU_OP_DIV,    32'hFFFF_FFF9, 32'd2,          0, "div_m7_2");
        do_op(MDU_OP_REM,    32'hFFFF_FFF9, 32'd2,          0, "rem_m7_2");
        do_op(MDU_OP_DIVU,   32'd100,       32'd7,          0, "divu_100_7");
        do_op(MDU_OP_REMU,   32'd100,       32'd7,          0, "remu_100_7");
        do_op(MDU_OP_DIVU,   32'h1234,      32'd0,          0, "divu_by0");
        do_op(MDU_OP_REM,    32'h1234,      32'd0,          0, "rem_by0");
        do_op(MDU_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF,  0, "div_ovf");
        do_op(MDU_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF,  0, "rem_ovf");
        do_op(MDU_OP_MUL,    32'd12345,     32'd678,        5, "hold5");

        // Flush during CALC: back to idle, no response ever
        op_i = MDU_OP_DIVU; a_i = 32'hDEAD_BEEF; b_i = 32'd13; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_calc", {61'b0, resp_valid_o, req_ready_o, busy_o}, 64'b010);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (resp_valid_o || busy_o) saw = 1'b1;
        end
        check("flush_noresp", {63'b0, saw}, 64'd0);

        // Flush together with a request in IDLE: not accepted
        op_i = MDU_OP_MUL; a_i = 32'd3; b_i = 32'd3; req_valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0; flush_i = 1'b0;
        check("flush_req", {61'b0, resp_valid_o, req_ready_o, busy_o}, 64'b010);

        // Flush in DONE beats resp_ready
        op_i = MDU_OP_DIVU; a_i = 32'd9; b_i = 32'd0; req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("fast_done", {63'b0, resp_valid_o}, 64'd1);
        flush_i = 1'b1; resp_ready_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; resp_ready_i = 1'b0;
        check("flush_done", {61'b0, resp_valid_o, req_ready_o, busy_o}, 64'b010);

        // Asynchronous reset in the middle of CALC
        op_i = MDU_OP_MULHU; a_i = $urandom; b_i = $urandom; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 check("async_rst", {29'b0, result_o, resp_valid_o, busy_o, req_ready_o},
                 {29'b0, 32'h0, 3'b001});
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        do_op(MDU_OP_MUL, 32'd3, 32'd5, 0, "post_rst");

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            do_op(op, a, b, $urandom_range(0, 2), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Takes the same rs1/rs2 operands that feed the ALU and returns a 32-bit result to the writeback mux.
- Replaces the combinational `*`, `/` and `%` paths with a radix-2 iterative datapath (33-cycle latency) to free area and timing.
- The pipeline stalls on `busy_o` until the response is accepted.

Parameters:
- XLEN, 32: operand and result width; only 32 is supported.
- FAST_SPECIAL, 1: when 1, divide-by-zero and signed overflow skip iteration and respond one cycle after accept.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  abort the current operation; no response is produced.
- req_valid_i  in  1  a request is present.
- req_ready_o  out  1  high only in IDLE.
- op_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- resp_valid_o  out  1  `result_o` is valid.
- resp_ready_i  in  1  the consumer accepts the result.
- result_o  out  XLEN  result of the operation.
- busy_o  out  1  high in CALC or DONE; the stall request to the pipeline.

Behaviour:
- Reset (async, `rst_i`=1): state IDLE, counter 0, all accumulators 0, `result_o`=0, `resp_valid_o`=0, `busy_o`=0, `req_ready_o`=1.
- States:
  - IDLE: `req_ready_o`=1. `req_valid_i`=1 latches op_i, |a|, |b|, result-sign and remainder-sign flags, counter=0.
    - If FAST_SPECIAL and (div-type with b=0, or DIV/REM with a=0x80000000 and b=0xFFFFFFFF): go to DONE with the special result loaded.
    - Otherwise go to CALC.
  - CALC: one iteration per cycle, 32 iterations (counter 0..31). After iteration 31, apply sign correction, select the result, go to DONE.
  - DONE: `resp_valid_o`=1 and `result_o` held stable. `resp_ready_i`=1 moves to IDLE; otherwise hold.
- Latency:
  - Accept at edge T gives `resp_valid_o` from T+33 (normal) or T+1 (fast special).
  - Back-to-back: the next request can be accepted one cycle after the response handshake.
- Operand sign treatment:
  - a signed for MUL, MULH, MULHSU, DIV, REM.
  - b signed for MUL, MULH, DIV, REM.
  - Unsigned operands are used as-is; signed operands are converted to magnitude (two's-complement negate when bit 31 is set).
- Multiply:
  - Shift-add on a 64-bit product: when the multiplier LSB is 1, add the multiplicand into the upper half, then shift right.
  - Final product is negated when sign(a) XOR sign(b) for the signed-operand pair.
  - MUL returns product[31:0]; the others return product[63:32].
- Divide:
  - Restoring: remainder = {rem, next dividend bit}; if ≥ |b|, subtract and set the quotient bit.
  - Quotient is negated when signs differ (signed ops); remainder takes the dividend's sign.
  - Division by zero: quotient 0xFFFFFFFF, remainder = a.
  - Overflow: quotient 0x80000000, remainder 0.
  - With FAST_SPECIAL=0 these values are forced after iteration instead.
- `flush_i`:
  - In any state, the next state is IDLE and `resp_valid_o` falls next cycle; no result is delivered.
  - Flush in the same cycle as `req_valid_i` in IDLE: the request is not accepted.
  - Flush has priority over `resp_ready_i`.
- Reset asserted mid-operation: immediate return to the reset values.
- The unit never accepts while busy. Inputs in non-IDLE states are ignored; `a_i`/`b_i` may change after accept.

Decomposition:
- Shared header (alongside ALU function codes): MDU_OP_MUL..MDU_OP_REMU funct3 constants, MDU state encodings IDLE/CALC/DONE.
- One natural sub-module: mdu_sign_fix (combinational). Produces operand magnitudes and sign flags at accept, and conditional negation of the 64-bit product and of the quotient/remainder at finish.
- Iteration datapath and FSM stay in mdu_seq.

Test Plan:
- MUL a=0xFFFFFFFF (-1), b=7 → `result_o`=0xFFFFFFF9, `resp_valid_o` exactly 33 cycles after accept; MULH same operands → 0xFFFFFFFF; MULHU → 0x00000006.
- MULHSU a=0x80000000, b=0xFFFFFFFF → 0x80000000; MULH a=0x80000000, b=0x80000000 → 0x40000000.
- DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU a=0x1234, b=0 → 0xFFFFFFFF and REM a=0x1234, b=0 → 0x1234, both 1 cycle after accept with FAST_SPECIAL=1; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Handshake: hold `resp_ready_i`=0 for 5 cycles in DONE → `result_o` stable, `req_ready_o`=0; a new request accepted only after the handshake; `flush_i` at CALC cycle 10 → IDLE next cycle, no `resp_valid_o`.
- Reset asserted mid-CALC (between clock edges) → `busy_o`/`resp_valid_o` drop asynchronously, `req_ready_o`=1, the following MUL 3*5 returns 15.
